up_down_counter: RTL and testbench
==================================

# up_down_counter

Loadable, synchronous up/down modulo counter with a 4-bit data path (module `up_down_counter`). Each rising clock edge it does one of three things: reset to zero, load a parallel value, or step one count up or down with wrap-around at the modulus. It sits behind the `count_if` signal bundle (clk, d_in, load, up_dn, rst, count), which the verification environment drives and samples.

## Interface
Parameters:
- `WIDTH`, default 4: bit width of `d_in` and `count`.
- `MOD`, default 12: counting modulus; the legal count range is 0..MOD-1. Must satisfy 2 ≤ MOD ≤ 2^WIDTH.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-low (0 = reset).
- `d_in`  input  WIDTH  parallel load value.
- `load`  input  1  active-high synchronous load enable.
- `up_dn`  input  1  direction: 1 = count up, 0 = count down.
- `count`  output  WIDTH  registered counter value.

`count_if` bundles exactly these five signals plus `clk` as its port. It adds no logic.

## Operation
The next value is evaluated at every rising `clk` edge with this fixed priority:
1. `rst == 0`: count ← 0. Reset overrides `load` and `up_dn`.
2. Else if `load == 1`: count ← `d_in`. The value is loaded unmodified, even if it is ≥ MOD.
3. Else if `up_dn == 1`:
   - if count ≥ MOD-1, count ← 0;
   - otherwise count ← count+1.
4. Else (`up_dn == 0`):
   - if count == 0, count ← MOD-1;
   - otherwise count ← count-1. This includes out-of-range values ≥ MOD, which step down normally until they reach the legal range.

Rules that apply in all cases:
- There is no hold or enable input. When not in reset and not loading, the counter steps on every cycle.
- All arithmetic is WIDTH bits and unsigned. There is no carry or terminal-count output.
- `count` is driven directly from the register, with no combinational path from the inputs.

## Timing
- Latency is one cycle. An input sampled at edge N shows on `count` just after edge N and holds until edge N+1.
- Reset value of `count` is 0.
- Out of reset, if `rst` is asserted at power-up the first edge with `rst == 0` forces 0. Before the first such edge `count` is X.
- Reset mid-operation: asserting `rst` for one edge clears `count` at that edge. Counting resumes from 0 on the first edge with `rst == 1`, in the direction `up_dn` selects at that edge.
- Load and direction may change on any cycle. Only their values at each rising edge matter.
- Simultaneous `load` and `up_dn`: load wins, and the count does not step on that edge.
- Wrap boundaries:
  - up: MOD-1 → 0;
  - down: 0 → MOD-1.
  - With the defaults these are 11 → 0 and 0 → 11.

## Test plan
- Reset: drive `rst=0` for 2 cycles from any state, with `load=1`, `d_in=7` → `count=0` on each edge. Release `rst` with `up_dn=1`, `load=0` → 1, 2, 3 on the following edges.
- Up wrap: load 9, then `up_dn=1` for 4 cycles → 10, 11, 0, 1.
- Down wrap: load 2, then `up_dn=0` for 4 cycles → 1, 0, 11, 10.
- Load priority: count=5, `load=1`, `d_in=3`, `up_dn=1` → count=3, with no increment on that edge. Next cycle with `load=0` → 4.
- Out-of-range load:
  - load 14, then `up_dn=1` → 0;
  - load 14, then `up_dn=0` for 3 cycles → 13, 12, 11.
- Randomized: 200 transactions of random `rst`/`load`/`up_dn`/`d_in`. Compare every edge against a reference model using the priority rules above. Zero mismatches required.

Source files
------------

// File: rtl/up_down_counter.sv
// Loadable up/down modulo-MOD counter; one-cycle latency, count is registered.
// No backpressure: steps every cycle unless in reset or loading.
module up_down_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("up_down_counter: MOD must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] next_count;

    // Out-of-range values (>= MOD, after a raw load) wrap to 0 going up
    // and step down normally until they re-enter the legal range.
    always_comb begin
        next_count = count;
        if (up_dn) begin
            next_count = (count >= MAX) ? '0 : count + ONE;
        end else begin
            next_count = (count == '0) ? MAX : count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= d_in;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed and random checks of up_down_counter with default WIDTH=4, MOD=12.
module tb_up_down_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d_in;
    logic             load;
    logic             up_dn;
    logic [WIDTH-1:0] count;

    int errors = 0;
    int checks = 0;

    up_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .load  (load),
        .up_dn (up_dn),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: count=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one edge's inputs away from the edge, then sample just after it.
    task automatic step(input logic r, input logic l, input logic u,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp,
                        input string tag);
        @(negedge clk);
        rst = r; load = l; up_dn = u; d_in = d;
        @(posedge clk);
        #1;
        check_val(tag, count, exp);
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] cur,
                                               input logic r, input logic l,
                                               input logic u,
                                               input logic [WIDTH-1:0] d);
        int c;
        c = int'(cur);
        if (!r) return '0;
        if (l) return d;
        if (u) return (c >= MOD - 1) ? '0 : WIDTH'(c + 1);
        return (c == 0) ? WIDTH'(MOD - 1) : WIDTH'(c - 1);
    endfunction

    initial begin
        logic [WIDTH-1:0] exp_q;
        logic             r, l, u;
        logic [WIDTH-1:0] d;

        rst = 1'b0; load = 1'b1; up_dn = 1'b1; d_in = 4'd7;

        // Reset beats load; counting resumes from 0
        step(0, 1, 1, 4'd7, 4'd0, "rst_edge0");
        step(0, 1, 1, 4'd7, 4'd0, "rst_edge1");
        step(1, 0, 1, 4'd0, 4'd1, "rst_rel1");
        step(1, 0, 1, 4'd0, 4'd2, "rst_rel2");
        step(1, 0, 1, 4'd0, 4'd3, "rst_rel3");

        // Up wrap 11 -> 0
        step(1, 1, 0, 4'd9, 4'd9,  "upw_load");
        step(1, 0, 1, 4'd0, 4'd10, "upw_10");
        step(1, 0, 1, 4'd0, 4'd11, "upw_11");
        step(1, 0, 1, 4'd0, 4'd0,  "upw_0");
        step(1, 0, 1, 4'd0, 4'd1,  "upw_1");

        // Down wrap 0 -> 11
        step(1, 1, 1, 4'd2, 4'd2,  "dnw_load");
        step(1, 0, 0, 4'd0, 4'd1,  "dnw_1");
        step(1, 0, 0, 4'd0, 4'd0,  "dnw_0");
        step(1, 0, 0, 4'd0, 4'd11, "dnw_11");
        step(1, 0, 0, 4'd0, 4'd10, "dnw_10");

        // Load wins over up_dn on the same edge
        step(1, 1, 0, 4'd5, 4'd5, "pri_load5");
        step(1, 1, 1, 4'd3, 4'd3, "pri_load3");
        step(1, 0, 1, 4'd3, 4'd4, "pri_next");

        // Out-of-range loads
        step(1, 1, 0, 4'd14, 4'd14, "oor_load_up");
        step(1, 0, 1, 4'd0,  4'd0,  "oor_up");
        step(1, 1, 1, 4'd14, 4'd14, "oor_load_dn");
        step(1, 0, 0, 4'd0,  4'd13, "oor_dn13");
        step(1, 0, 0, 4'd0,  4'd12, "oor_dn12");
        step(1, 0, 0, 4'd0,  4'd11, "oor_dn11");

        // One-edge reset mid-run, then resume downward
        step(0, 0, 0, 4'd0, 4'd0,  "mid_rst");
        step(1, 0, 0, 4'd0, 4'd11, "mid_resume_dn");

        exp_q = 4'd11;
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 3) == 0);
            u = 1'($urandom_range(0, 1));
            d = WIDTH'($urandom_range(0, 15));
            exp_q = model(exp_q, r, l, u, d);
            step(r, l, u, d, exp_q, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
